irq_gen: RTL

- Interrupt-request client of the PCIe endpoint arbiter; sits directly downstream of it on the IRQ port.
- Coalesces data-path events (e.g. RX buffer written to host) into legacy interrupts.
- Requests the endpoint via irq_reqep and waits for a one-cycle irq_trn grant.
- Holds irq_drvn while it runs the endpoint cfg_interrupt handshake, then releases the endpoint.

---
 rtl/irq_gen.sv | 123 ++++++++++++
 1 files changed

// File: rtl/irq_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | irq_gen : coalesces data-path events into legacy PCIe interrupts         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module irq_gen #(
  parameter int TIMER_W = 16,
  parameter int MAX_EVT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               evt,
  input  logic               irq_en,
  input  logic [TIMER_W-1:0] coalesce_timeout,
  output logic               irq_reqep,
  input  logic               irq_trn,
  output logic               irq_drvn,
  output logic               cfg_interrupt_n,
  input  logic               cfg_interrupt_rdy_n,
  output logic [31:0]        irq_cnt
);

  localparam int c_CNT_W = $clog2(MAX_EVT + 1);
  localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_EVT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_REQ   = 3'd2,
    S_ISSUE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_evt_cnt;
  logic [TIMER_W-1:0]   r_timer;
  logic [TIMER_W-1:0]   r_timeout;
  logic                 r_reqep;
  logic                 r_drvn;
  logic                 r_int_n;
  logic [31:0]          r_irq_cnt;

  logic                 w_evt_ok;
  logic [c_CNT_W-1:0]   w_cnt_next;

  assign w_evt_ok   = evt & irq_en;
  assign w_cnt_next = (w_evt_ok && (r_evt_cnt < c_MAX_CNT)) ? r_evt_cnt + c_CNT_W'(1) : r_evt_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_evt_cnt <= '0;
      r_timer   <= '0;
      r_timeout <= '0;
      r_reqep   <= 1'b0;
      r_drvn    <= 1'b0;
      r_int_n   <= 1'b1;
      r_irq_cnt <= '0;
    end else begin
      r_evt_cnt <= w_cnt_next;
      case (r_state)
        S_IDLE: begin
          if (w_evt_ok) begin
            r_state   <= S_ARMED;
            r_timer   <= '0;
            r_timeout <= coalesce_timeout;
          end
        end
        S_ARMED: begin
          if (!irq_en) begin
            r_state   <= S_IDLE;
            r_evt_cnt <= '0;
          end else if ((r_timer == r_timeout) || (r_evt_cnt >= c_MAX_CNT)) begin
            r_state <= S_REQ;
            r_reqep <= 1'b1;
          end else if (!(&r_timer)) begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end
        S_REQ: begin
          // A grant outranks a simultaneous disable: the arbiter already handed us the endpoint.
          if (irq_trn) begin
            r_state   <= S_ISSUE;
            r_reqep   <= 1'b0;
            r_drvn    <= 1'b1;
            r_int_n   <= 1'b0;
            r_evt_cnt <= w_evt_ok ? c_CNT_W'(1) : '0;
          end else if (!irq_en) begin
            r_state   <= S_IDLE;
            r_reqep   <= 1'b0;
            r_evt_cnt <= '0;
          end
        end
        S_ISSUE: begin
          if (!cfg_interrupt_rdy_n) begin
            r_state   <= S_DONE;
            r_int_n   <= 1'b1;
            r_irq_cnt <= r_irq_cnt + 32'd1;
          end
        end
        S_DONE: begin
          r_drvn <= 1'b0;
          if ((w_cnt_next != '0) && irq_en) begin
            r_state   <= S_ARMED;
            r_timer   <= '0;
            r_timeout <= coalesce_timeout;
          end else begin
            r_state   <= S_IDLE;
            r_evt_cnt <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign irq_reqep       = r_reqep;
  assign irq_drvn        = r_drvn;
  assign cfg_interrupt_n = r_int_n;
  assign irq_cnt         = r_irq_cnt;

endmodule
`default_nettype wire
